// File: rtl/magic_device_arbiter.sv
// Round-robin arbiter giving NUM_REQ requesters shared, one-at-a-time read access to a single device.
// Optional WAIT-state timeout is compiled in with macro MAGIC_DEVICE_ARB_TIMEOUT_EN.
module magic_device_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [12*NUM_REQ-1:0]   req_select,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      resp_valid,
    output logic [63:0]             resp_data,
    output logic                    resp_err,
    output logic [11:0]             dev_read_select,
    output logic                    dev_read_ready,
    input  logic                    dev_read_valid,
    input  logic [63:0]             dev_read_data,
    output logic                    busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_badParams
        $error("magic_device_arbiter: parameter out of legal range");
    end

    logic [1:0]         r_state;
    logic [IDX_W-1:0]   r_lastGrant;
    logic [IDX_W-1:0]   r_owner;
    logic [11:0]        r_select;
    logic [63:0]        r_data;

    logic               w_grantValid;
    logic [IDX_W-1:0]   w_grantIdx;
    logic [11:0]        w_grantSel;
    logic [NUM_REQ-1:0] w_grantOneHot;
    logic [NUM_REQ-1:0] w_ownerOneHot;
    int                 w_cand;

    // First requesting index at or after last_grant+1, wrapping around.
    always_comb begin
        w_grantValid = 1'b0;
        w_grantIdx   = '0;
        w_cand       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = (int'(r_lastGrant) + 1 + k) % NUM_REQ;
            if (!w_grantValid && req_valid[w_cand[IDX_W-1:0]]) begin
                w_grantValid = 1'b1;
                w_grantIdx   = w_cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        w_grantSel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grantIdx == IDX_W'(i)) begin
                w_grantSel = req_select[12*i +: 12];
            end
        end
    end

    assign w_grantOneHot = NUM_REQ'(1) << w_grantIdx;
    assign w_ownerOneHot = NUM_REQ'(1) << r_owner;

    // Gated by reset_n so every output reads 0 while reset is held.
    assign req_ready       = (reset_n && r_state == S_IDLE && w_grantValid) ? w_grantOneHot : '0;
    assign resp_valid      = (r_state == S_RESP) ? w_ownerOneHot : '0;
    assign resp_data       = r_data;
    assign dev_read_ready  = (r_state == S_WAIT);
    assign dev_read_select = (r_state == S_WAIT) ? r_select : '0;
    assign busy            = (r_state != S_IDLE);

`ifdef MAGIC_DEVICE_ARB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    logic [15:0] r_count;
    logic        r_err;

    assign resp_err = (r_state == S_RESP) && r_err;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_lastGrant <= IDX_W'(NUM_REQ - 1);
            r_owner     <= '0;
            r_select    <= '0;
            r_data      <= '0;
            r_count     <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grantValid) begin
                        r_owner  <= w_grantIdx;
                        r_select <= w_grantSel;
                        r_count  <= '0;
                        r_state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Device data wins over a timeout landing on the same cycle.
                    if (dev_read_valid) begin
                        r_data  <= dev_read_data;
                        r_err   <= 1'b0;
                        r_state <= S_RESP;
                    end else if (r_count == TIMEOUT_LIMIT) begin
                        r_data  <= '1;
                        r_err   <= 1'b1;
                        r_state <= S_RESP;
                    end else begin
                        r_count <= r_count + 16'd1;
                    end
                end
                S_RESP: begin
                    r_lastGrant <= r_owner;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
`else
    assign resp_err = 1'b0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_lastGrant <= IDX_W'(NUM_REQ - 1);
            r_owner     <= '0;
            r_select    <= '0;
            r_data      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grantValid) begin
                        r_owner  <= w_grantIdx;
                        r_select <= w_grantSel;
                        r_state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (dev_read_valid) begin
                        r_data  <= dev_read_data;
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_lastGrant <= r_owner;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_magic_device_arbiter.sv
// Self-checking bench for magic_device_arbiter: vector table plus hand-written reset,
// fairness, spurious-valid and (with MAGIC_DEVICE_ARB_TIMEOUT_EN) timeout sequences.
module tb_magic_device_arbiter;

    logic         clock;
    logic         reset_n;
    logic [3:0]   req_valid;
    logic [47:0]  req_select;
    logic [3:0]   req_ready;
    logic [3:0]   resp_valid;
    logic [63:0]  resp_data;
    logic         resp_err;
    logic [11:0]  dev_read_select;
    logic         dev_read_ready;
    logic         dev_read_valid;
    logic [63:0]  dev_read_data;
    logic         busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          owner;
        logic [63:0] data;
        logic        err;
    } respT;

    respT expQ[$];

    typedef struct {
        logic [3:0]  reqMask;
        logic [47:0] selAll;
        int          delay;
        logic [63:0] devData;
        int          expGrant;
        logic [11:0] expSel;
    } vecT;

    vecT vecs[8];

    magic_device_arbiter #(
        .NUM_REQ        (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .req_valid       (req_valid),
        .req_select      (req_select),
        .req_ready       (req_ready),
        .resp_valid      (resp_valid),
        .resp_data       (resp_data),
        .resp_err        (resp_err),
        .dev_read_select (dev_read_select),
        .dev_read_ready  (dev_read_ready),
        .dev_read_valid  (dev_read_valid),
        .dev_read_data   (dev_read_data),
        .busy            (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard: every response pulse must match the oldest expected entry.
    always @(negedge clock) begin
        if (resp_valid != 4'b0000) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected resp_valid", resp_valid, 4'b0000);
            end else begin
                respT e;
                e = expQ.pop_front();
                checkOutput("sb resp_valid", resp_valid, 4'b0001 << e.owner);
                checkOutput("sb resp_data", resp_data, e.data);
                checkOutput("sb resp_err", resp_err, e.err);
            end
        end
    end

    // One full transaction starting in IDLE just after a rising edge; the granted
    // requester drops its request once accepted.
    task automatic applyStimulus(input logic [3:0] mask, input logic [47:0] sel, input int g,
                                 input int delay, input logic [63:0] data, input logic [11:0] expSel,
                                 input logic expErr);
        respT e;
        req_valid      = mask;
        req_select     = sel;
        dev_read_valid = 1'b0;
        @(negedge clock);
        checkOutput("grant req_ready", req_ready, 4'b0001 << g);
        checkOutput("grant busy", busy, 1'b0);
        checkOutput("grant dev_read_ready", dev_read_ready, 1'b0);
        e.owner = g;
        e.data  = data;
        e.err   = expErr;
        expQ.push_back(e);
        tick();
        req_valid[g] = 1'b0;
        for (int d = 0; d < delay; d++) begin
            @(negedge clock);
            checkOutput("wait dev_read_ready", dev_read_ready, 1'b1);
            checkOutput("wait dev_read_select", dev_read_select, expSel);
            checkOutput("wait req_ready", req_ready, 4'b0000);
            checkOutput("wait resp_valid", resp_valid, 4'b0000);
            tick();
        end
        dev_read_valid = 1'b1;
        dev_read_data  = data;
        @(negedge clock);
        checkOutput("valid dev_read_ready", dev_read_ready, 1'b1);
        checkOutput("valid dev_read_select", dev_read_select, expSel);
        tick();
        dev_read_valid = 1'b0;
        @(negedge clock);
        checkOutput("resp resp_valid", resp_valid, 4'b0001 << g);
        checkOutput("resp dev_read_ready", dev_read_ready, 1'b0);
        checkOutput("resp busy", busy, 1'b1);
        tick();
    endtask

    task automatic applyReset(input int cycles);
        reset_n        = 1'b0;
        req_valid      = '0;
        dev_read_valid = 1'b0;
        repeat (cycles) tick();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n        = 1'b0;
        req_valid      = '0;
        req_select     = '0;
        dev_read_valid = 1'b0;
        dev_read_data  = '0;

        vecs[0] = '{4'b0100, 48'h111_0A5_222_333, 4, 64'h1234,                2, 12'h0A5};
        vecs[1] = '{4'b1111, 48'hABC_DEF_123_456, 1, 64'hDEAD_BEEF_0000_0001, 3, 12'hABC};
        vecs[2] = '{4'b0110, 48'hABC_DEF_123_456, 0, 64'hFFFF_0000_FFFF_0000, 1, 12'h123};
        vecs[3] = '{4'b0011, 48'h0F0_E1E_D2D_C3C, 2, 64'h8000_0000_0000_0000, 0, 12'hC3C};
        vecs[4] = '{4'b1000, 48'hFFF_000_000_000, 0, 64'h0123_4567_89AB_CDEF, 3, 12'hFFF};
        vecs[5] = '{4'b1001, 48'h800_000_000_001, 1, 64'h1,                   0, 12'h001};
        vecs[6] = '{4'b0001, 48'h000_000_000_7FF, 2, 64'h7777,                0, 12'h7FF};
        vecs[7] = '{4'b1110, 48'h321_654_987_000, 0, 64'hA5A5_5A5A_A5A5_5A5A, 1, 12'h987};

        repeat (3) tick();
        checkOutput("reset req_ready", req_ready, 4'b0000);
        checkOutput("reset resp_valid", resp_valid, 4'b0000);
        checkOutput("reset resp_err", resp_err, 1'b0);
        checkOutput("reset resp_data", resp_data, 64'h0);
        checkOutput("reset dev_read_ready", dev_read_ready, 1'b0);
        checkOutput("reset dev_read_select", dev_read_select, 12'h000);
        checkOutput("reset busy", busy, 1'b0);
        reset_n = 1'b1;
        tick();

        for (int r = 0; r < 8; r++) begin
            applyStimulus(vecs[r].reqMask, vecs[r].selAll, vecs[r].expGrant, vecs[r].delay,
                          vecs[r].devData, vecs[r].expSel, 1'b0);
        end

        // Device valid while idle must be ignored entirely.
        req_valid      = '0;
        dev_read_valid = 1'b1;
        dev_read_data  = 64'hBAD0_BAD0_BAD0_BAD0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            checkOutput("spurious busy", busy, 1'b0);
            checkOutput("spurious resp_valid", resp_valid, 4'b0000);
            checkOutput("spurious dev_read_ready", dev_read_ready, 1'b0);
            checkOutput("idle resp_data hold", resp_data, 64'hA5A5_5A5A_A5A5_5A5A);
            tick();
        end
        dev_read_valid = 1'b0;
        applyStimulus(4'b1111, 48'h444_333_222_111, 2, 1, 64'h2222, 12'h333, 1'b0);

        // Fairness: everyone requesting, device answering on the first WAIT cycle.
        applyReset(2);
        req_valid      = 4'b1111;
        req_select     = 48'h333_222_111_000;
        dev_read_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            respT e;
            int   g;
            g             = k % 4;
            dev_read_data = 64'hFA00 + 64'(k);
            @(negedge clock);
            checkOutput("fair req_ready", req_ready, 4'b0001 << g);
            e.owner = g;
            e.data  = 64'hFA00 + 64'(k);
            e.err   = 1'b0;
            expQ.push_back(e);
            tick();
            @(negedge clock);
            checkOutput("fair dev_read_ready", dev_read_ready, 1'b1);
            checkOutput("fair dev_read_select", dev_read_select, 12'h111 * 12'(g));
            tick();
            @(negedge clock);
            checkOutput("fair resp_valid", resp_valid, 4'b0001 << g);
            tick();
        end
        req_valid      = '0;
        dev_read_valid = 1'b0;

        // Reset during the second WAIT cycle aborts silently and restores priority to 0.
        req_valid  = 4'b1111;
        req_select = 48'hD00_C00_B00_A00;
        @(negedge clock);
        checkOutput("abort grant", req_ready, 4'b0010);
        tick();
        @(negedge clock);
        checkOutput("abort wait1 dev_read_ready", dev_read_ready, 1'b1);
        tick();
        reset_n = 1'b0;
        #1;
        checkOutput("abort dev_read_ready", dev_read_ready, 1'b0);
        checkOutput("abort busy", busy, 1'b0);
        checkOutput("abort req_ready", req_ready, 4'b0000);
        checkOutput("abort dev_read_select", dev_read_select, 12'h000);
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            checkOutput("abort resp_valid", resp_valid, 4'b0000);
            tick();
        end
        reset_n = 1'b1;
        applyStimulus(4'b1111, 48'hD00_C00_B00_A00, 0, 1, 64'h0BAD_CAFE, 12'hA00, 1'b0);

`ifdef MAGIC_DEVICE_ARB_TIMEOUT_EN
        begin
            respT e;
            req_valid  = 4'b0100;
            req_select = 48'h000_0CC_000_000;
            @(negedge clock);
            checkOutput("timeout grant", req_ready, 4'b0100);
            e.owner = 2;
            e.data  = 64'hFFFF_FFFF_FFFF_FFFF;
            e.err   = 1'b1;
            expQ.push_back(e);
            tick();
            req_valid = '0;
            for (int c = 0; c < 9; c++) begin
                @(negedge clock);
                checkOutput("timeout dev_read_ready", dev_read_ready, 1'b1);
                checkOutput("timeout early resp", resp_valid, 4'b0000);
                tick();
            end
            @(negedge clock);
            checkOutput("timeout resp_valid", resp_valid, 4'b0100);
            checkOutput("timeout resp_err", resp_err, 1'b1);
            tick();
        end
        applyStimulus(4'b0001, 48'h000_000_000_055, 0, 8, 64'h55, 12'h055, 1'b0);
`endif

        repeat (2) tick();
        checkOutput("scoreboard drained", 64'(expQ.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/magic_device_arbiter.md
MAGIC_DEVICE_ARBITER -- requirements
Module: magic_device_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters, legal 2..8.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, WAIT-state cycle limit, legal 1..65535; used only when the timeout feature is compiled in.
REQ-003 SHALL have port clock  input  1  sole clock, all state rising-edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester read request.
REQ-006 SHALL have port req_select  input  12*NUM_REQ  per-requester select; requester i occupies bits [12*i+11:12*i].
REQ-007 SHALL have port req_ready  output  NUM_REQ  one-hot, one-cycle acceptance pulse.
REQ-008 SHALL have port resp_valid  output  NUM_REQ  one-hot, one-cycle response pulse.
REQ-009 SHALL have port resp_data  output  64  response data, shared by all requesters.
REQ-010 SHALL have port resp_err  output  1  timeout flag, qualified by resp_valid.
REQ-011 SHALL have port dev_read_select  output  12  select to device.
REQ-012 SHALL have port dev_read_ready  output  1  request strobe to device.
REQ-013 SHALL have port dev_read_valid  input  1  device data valid.
REQ-014 SHALL have port dev_read_data  input  64  device data.
REQ-015 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP; one transaction outstanding at a time.
REQ-017 IDLE: if any req_valid is high, SHALL grant exactly one requester round-robin, searching from index (last_grant+1) mod NUM_REQ upward with wrap.
REQ-018 In the grant cycle, SHALL pulse req_ready[g], latch req_select[g] and owner g, then go to WAIT next cycle.
REQ-019 WAIT: SHALL drive dev_read_ready=1 and dev_read_select=latched select, both stable until exit.
REQ-020 WAIT: on the first cycle dev_read_valid=1 is sampled, SHALL capture dev_read_data, clear the pending error, and go to RESP.
REQ-021 RESP: SHALL assert resp_valid[owner] for exactly one cycle with resp_data=captured data, set last_grant=owner, and return to IDLE.
REQ-022 SHALL NOT grant in RESP or WAIT; a new grant occurs no earlier than the first IDLE cycle after RESP.
REQ-023 Latency: grant at cycle N, dev_read_ready high from N+1, valid at cycle M>=N+1, resp_valid at M+1; minimum 3 cycles per transaction.
REQ-024 SHALL ignore dev_read_valid outside WAIT.
REQ-025 A requester dropping req_valid after its grant SHALL NOT abort the transaction; the response is still delivered.
REQ-026 When idle, dev_read_ready, req_ready, resp_valid and resp_err SHALL be 0; resp_data holds its last value.

Reset
REQ-027 reset_n low SHALL force state=IDLE, last_grant=NUM_REQ-1 (so requester 0 wins first), all outputs 0, captured data 0, timeout counter 0.
REQ-028 Reset asserted mid-WAIT or mid-RESP SHALL abort the transaction silently, with no resp_valid pulse, and dev_read_ready low immediately (asynchronous).

Configuration
REQ-029 With macro MAGIC_DEVICE_ARB_TIMEOUT_EN defined, the WAIT state SHALL count cycles from 0; when the count reaches TIMEOUT_CYCLES with no dev_read_valid, SHALL go to RESP with resp_data=64'hFFFF_FFFF_FFFF_FFFF and resp_err=1.
REQ-030 If dev_read_valid arrives in the same cycle the limit is reached, SHALL take the valid data and set resp_err=0.
REQ-031 Without MAGIC_DEVICE_ARB_TIMEOUT_EN, WAIT SHALL be unbounded, resp_err SHALL be tied to 0, and no counter SHALL exist.

Verification
REQ-032 Single request: req_valid[2]=1, select=12'h0A5, device valid after 4 cycles with data 64'h1234 -> req_ready[2] pulse; dev_read_select=0A5; resp_valid[2] one cycle after valid with data 64'h1234.
REQ-033 Fairness: all 4 req_valid held high, device responds in 1 cycle -> grant order 0,1,2,3,0; each transaction takes 3 cycles.
REQ-034 Spurious valid: dev_read_valid=1 while IDLE -> no resp_valid, no state change.
REQ-035 Reset mid-WAIT: reset_n low at cycle 2 of WAIT -> dev_read_ready=0 at once; no resp_valid; after release, requester 0 is granted first.
REQ-036 Timeout (macro on, TIMEOUT_CYCLES=8): device never responds -> resp_valid[owner] with data all-ones and resp_err=1, 9 cycles after dev_read_ready rose.
REQ-037 Timeout race (macro on): valid with data 64'h55 on the limit cycle -> resp_data=64'h55, resp_err=0.
